// File: rtl/apb_req_arbiter_if.sv
// apb_req_arbiter_if: APB bus between the apb_req_arbiter master and one slave.
interface apb_req_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;
   modport master (output paddr, pwdata, psel, penable, pwrite, input prdata, pready, pslverr);
   modport slave (input paddr, pwdata, psel, penable, pwrite, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter for two requesters driving one APB master port.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS with an error after TIMEOUT_CYCLES cycles without pready.
module apb_req_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                pclk,
   input  logic                presetn,
   input  logic [1:0]          req_valid,
   input  logic [1:0]          req_write,
   input  logic [2*ADDR_W-1:0] req_addr,
   input  logic [2*DATA_W-1:0] req_wdata,
   output logic [1:0]          req_grant,
   output logic [1:0]          req_done,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy,
   apb_req_arbiter_if.master   apb
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
   state_t state;
   logic   owner;
   logic   last;
   logic   win;
   logic   timeout;
   // On a tie the requester that was not granted last wins; reset leaves last=1 so requester 0 goes first
   assign win       = req_valid == 2'b11 ? ~last : req_valid[1];
   assign req_grant = (state == IDLE && presetn && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign busy      = state != IDLE;
`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
   assign timeout = state == ACCESS && !apb.pready && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) cnt <= '0;
      else cnt <= state == ACCESS ? cnt + CNT_W'(1) : '0;
`else
   assign timeout = 1'b0 && TIMEOUT_CYCLES != 0;
`endif
   always_ff @(posedge pclk or negedge presetn)
      if (!presetn) begin
         state       <= IDLE;
         owner       <= 1'b0;
         last        <= 1'b1;
         apb.paddr   <= '0;
         apb.pwdata  <= '0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         req_done    <= 2'b00;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         req_done <= 2'b00;
         case (state)
            IDLE:
               if (|req_grant) begin
                  owner       <= win;
                  last        <= win;
                  apb.paddr   <= win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                  apb.pwdata  <= win ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                  apb.pwrite  <= req_write[win];
                  apb.psel    <= 1'b1;
                  apb.penable <= 1'b0;
                  state       <= SETUP;
               end
            SETUP: begin
               apb.penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS:
               if (apb.pready || timeout) begin
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  req_done    <= owner ? 2'b10 : 2'b01;
                  rsp_rdata   <= (apb.pwrite || timeout) ? '0 : apb.prdata;
                  rsp_err     <= timeout | apb.pslverr;
                  state       <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed scoreboard bench for apb_req_arbiter with a memory-backed APB slave.
module tb_apb_req_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   typedef struct {
      logic [1:0]    done;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;
   logic            pclk = 1'b0;
   logic            presetn = 1'b0;
   logic [1:0]      req_valid = 2'b00;
   logic [1:0]      req_write = 2'b00;
   logic [2*AW-1:0] req_addr = '0;
   logic [2*DW-1:0] req_wdata = '0;
   logic [1:0]      req_grant;
   logic [1:0]      req_done;
   logic [DW-1:0]   rsp_rdata;
   logic            rsp_err;
   logic            busy;
   int              tests = 0;
   int              fails = 0;
   rsp_t            dq[$];
   logic [1:0]      gq[$];
   rsp_t            e_rsp;
   logic            prev_psel = 1'b0;
   logic [AW-1:0]   setup_addr = '0;
   logic [DW-1:0]   mem[256];
   int              acc_cyc = 0;
   int              wait_n = 1;
   bit              hang = 1'b0;
   int              lat;
   int              n;
   int              cyc;

   apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

   apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
      .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .apb(apb)
   );

   always #5 pclk = ~pclk;

   // slave: pready one cycle after penable rises, error at 0x40, hang holds pready low
   always_comb begin
      apb.pready  = apb.psel && apb.penable && !hang && acc_cyc >= wait_n;
      apb.pslverr = apb.paddr == 32'h40;
      apb.prdata  = apb.pslverr ? 32'hBAD0_BAD0 : mem[apb.paddr[7:0]];
   end
   always @(posedge pclk) begin
      acc_cyc <= (apb.psel && apb.penable && !apb.pready) ? acc_cyc + 1 : 0;
      if (apb.psel && apb.penable && apb.pready && apb.pwrite) mem[apb.paddr[7:0]] <= apb.pwdata;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expire(input string name);
      tests++;
      fails++;
      $display("FAIL %s: got no response expected one within bound", name);
   endtask

   always @(negedge pclk) begin
      if (req_grant != 2'b00) begin
         if (gq.size() == 0) check("unexpected grant", req_grant, 2'b00);
         else check("grant", req_grant, gq.pop_front());
      end
      if (req_done != 2'b00) begin
         if (dq.size() == 0) check("unexpected done", req_done, 2'b00);
         else begin
            e_rsp = dq.pop_front();
            check("done", req_done, e_rsp.done);
            check("rdata", rsp_rdata, e_rsp.rdata);
            check("err", rsp_err, e_rsp.err);
            check("psel low on done", apb.psel, 1'b0);
         end
      end
      if (busy) check("grant while busy", req_grant, 2'b00);
      check("busy vs psel", busy, apb.psel);
      if (apb.psel && !prev_psel) begin
         check("setup penable", apb.penable, 1'b0);
         setup_addr = apb.paddr;
      end
      if (apb.psel && apb.penable) check("paddr stable", apb.paddr, setup_addr);
      prev_psel = apb.psel;
   end

   task automatic issue(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input bit err, output int lt);
      gq.push_back(r != 0 ? 2'b10 : 2'b01);
      dq.push_back('{r != 0 ? 2'b10 : 2'b01, rd, err});
      req_write[r] = wr;
      req_addr[r*AW +: AW] = a;
      req_wdata[r*DW +: DW] = d;
      req_valid[r] = 1'b1;
      @(posedge pclk); #1;
      req_valid[r] = 1'b0;
      lt = 1;
      while (req_done == 2'b00 && lt < 64) begin
         @(posedge pclk); #1;
         lt++;
      end
      if (lt >= 64) expire("done wait");
      @(posedge pclk); #1;
   endtask

   task automatic drain(input string name);
      int c = 0;
      while (dq.size() != 0 && c < 100) begin
         @(posedge pclk); #1;
         c++;
      end
      if (dq.size() != 0) expire(name);
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit: got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      repeat (3) @(posedge pclk); #1;
      check("reset psel", apb.psel, 1'b0);
      check("reset penable", apb.penable, 1'b0);
      check("reset pwrite", apb.pwrite, 1'b0);
      check("reset paddr", apb.paddr, 32'h0);
      check("reset pwdata", apb.pwdata, 32'h0);
      check("reset done", req_done, 2'b00);
      check("reset err", rsp_err, 1'b0);
      check("reset rdata", rsp_rdata, 32'h0);
      presetn = 1'b1;
      @(posedge pclk); #1;
      issue(0, 1'b1, 32'h05, 32'hDEAD_BEEF, 32'h0, 1'b0, lat);
      check("write latency", lat, 4);
      issue(1, 1'b0, 32'h05, 32'h0, 32'hDEAD_BEEF, 1'b0, lat);
      check("read latency", lat, 4);
      // contention: both held, expect 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         gq.push_back(i % 2 == 0 ? 2'b01 : 2'b10);
         dq.push_back('{i % 2 == 0 ? 2'b01 : 2'b10, 32'h0, 1'b0});
      end
      req_write = 2'b11;
      req_addr = {32'h20, 32'h10};
      req_wdata = {32'h2222_0000, 32'h1111_0000};
      req_valid = 2'b11;
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 100) begin
         @(negedge pclk);
         cyc++;
         if (req_grant != 2'b00) n++;
      end
      @(posedge pclk); #1;
      req_valid = 2'b00;
      if (n < 4) expire("contention grants");
      drain("contention done");
      issue(0, 1'b0, 32'h20, 32'h0, 32'h2222_0000, 1'b0, lat);
      issue(1, 1'b0, 32'h10, 32'h0, 32'h1111_0000, 1'b0, lat);
      issue(0, 1'b0, 32'h40, 32'h0, 32'hBAD0_BAD0, 1'b1, lat);
      // reset during ACCESS: requester 0 last granted, so only a reset pointer favours 0 on the next tie
      hang = 1'b1;
      gq.push_back(2'b01);
      req_write[0] = 1'b0;
      req_addr[AW-1:0] = 32'h05;
      req_valid[0] = 1'b1;
      @(posedge pclk); #1;
      req_valid[0] = 1'b0;
      cyc = 0;
      while (!apb.penable && cyc < 10) begin
         @(posedge pclk); #1;
         cyc++;
      end
      if (!apb.penable) expire("reach access");
      @(posedge pclk); #3;
      presetn = 1'b0;
      #1;
      check("reset psel immediate", apb.psel, 1'b0);
      check("reset penable immediate", apb.penable, 1'b0);
      check("reset busy immediate", busy, 1'b0);
      repeat (2) @(posedge pclk); #1;
      check("no done in reset", req_done, 2'b00);
      hang = 1'b0;
      presetn = 1'b1;
      @(posedge pclk); #1;
      gq.push_back(2'b01);
      dq.push_back('{2'b01, 32'hDEAD_BEEF, 1'b0});
      req_write = 2'b00;
      req_addr = {32'h10, 32'h05};
      req_valid = 2'b11;
      @(posedge pclk); #1;
      req_valid = 2'b00;
      drain("post reset done");
      @(posedge pclk); #1;
`ifdef APB_ARB_TIMEOUT_EN
      hang = 1'b1;
      gq.push_back(2'b10);
      dq.push_back('{2'b10, 32'h0, 1'b1});
      req_write[1] = 1'b0;
      req_addr[2*AW-1:AW] = 32'h05;
      req_valid[1] = 1'b1;
      @(posedge pclk); #1;
      req_valid[1] = 1'b0;
      n = 0;
      cyc = 0;
      while (req_done == 2'b00 && cyc < 64) begin
         @(negedge pclk);
         cyc++;
         if (apb.penable) n++;
      end
      if (req_done == 2'b00) expire("timeout done");
      check("access cycles before timeout", n, 16);
      hang = 1'b0;
      @(posedge pclk); #1;
      check("idle after timeout", busy, 1'b0);
`else
      hang = 1'b1;
      gq.push_back(2'b10);
      dq.push_back('{2'b10, 32'hDEAD_BEEF, 1'b0});
      req_write[1] = 1'b0;
      req_addr[2*AW-1:AW] = 32'h05;
      req_valid[1] = 1'b1;
      @(posedge pclk); #1;
      req_valid[1] = 1'b0;
      repeat (40) @(posedge pclk); #1;
      check("waits for pready busy", busy, 1'b1);
      check("waits for pready penable", apb.penable, 1'b1);
      hang = 1'b0;
      drain("late pready done");
`endif
      repeat (2) @(posedge pclk); #1;
      check("grant queue drained", gq.size(), 0);
      check("done queue drained", dq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
